// File: rtl/demux4_skid_pkg.sv
// Shared types and helpers for the 1-to-4 stream distribution block.
package demux4_skid_pkg;

  localparam int NUM_DEST = 4;

  typedef logic [1:0] dest_sel_t;

  function automatic logic [NUM_DEST-1:0] onehot4(input dest_sel_t sel);
    logic [NUM_DEST-1:0] vec;
    vec      = '0;
    vec[sel] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/demux4_skid_skid_buffer.sv
// Generic 2-entry valid/ready register slice: a main entry facing downstream and
// a skid entry that absorbs one word while the main entry is stalled.
module skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic             m_valid, s_valid, ready_q;
  logic [WIDTH-1:0] m_data, s_data;
  logic             m_valid_nxt, s_valid_nxt;
  logic [WIDTH-1:0] m_data_nxt, s_data_nxt;
  logic             accept, drain;

  assign accept = in_valid & ready_q;
  assign drain  = m_valid & out_ready;

  // The skid entry always refills main before new input, which keeps order strict.
  always_comb begin
    m_valid_nxt = m_valid;
    m_data_nxt  = m_data;
    s_valid_nxt = s_valid;
    s_data_nxt  = s_data;
    if (!m_valid || drain) begin
      if (s_valid) begin
        m_valid_nxt = 1'b1;
        m_data_nxt  = s_data;
        s_valid_nxt = 1'b0;
      end else begin
        m_valid_nxt = accept;
        if (accept) begin
          m_data_nxt = in_data;
        end
      end
    end else if (accept) begin
      s_valid_nxt = 1'b1;
      s_data_nxt  = in_data;
    end
  end

  // ready_q mirrors ~s_valid so in_ready comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= '0;
      s_data  <= '0;
      ready_q <= 1'b1;
    end else begin
      m_valid <= m_valid_nxt;
      s_valid <= s_valid_nxt;
      m_data  <= m_data_nxt;
      s_data  <= s_data_nxt;
      ready_q <= ~s_valid_nxt;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign count     = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: rtl/demux4_skid.sv
// Registered 1-to-4 demultiplexer: words carry their destination through a skid
// buffer and are presented to exactly one of four consumers, in arrival order.
module demux4_skid
  import demux4_skid_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [1:0]          in_sel,
  output logic [NUM_DEST-1:0] out_valid,
  input  logic [NUM_DEST-1:0] out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [1:0]          count
);

  logic             m_valid;
  logic [WIDTH+1:0] m_word;
  dest_sel_t        m_sel;
  logic             m_ready;

  skid_buffer #(
    .WIDTH(WIDTH + 2)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({in_sel, in_data}),
    .out_valid(m_valid),
    .out_ready(m_ready),
    .out_data (m_word),
    .count    (count)
  );

  // Only the addressed consumer's ready can retire the head word.
  assign m_sel     = m_word[WIDTH+1:WIDTH];
  assign m_ready   = out_ready[m_sel];
  assign out_valid = m_valid ? onehot4(m_sel) : '0;
  assign out_data  = m_word[WIDTH-1:0];

endmodule

// File: tb/tb_demux4_skid.sv
// Bench for demux4_skid: directed scenarios with literal expectations plus random
// traffic, all compared each cycle against a depth-2 FIFO reference model.
module tb_demux4_skid;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  int total = 0;
  int bad   = 0;

  demux4_skid #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       sel;
    logic [WIDTH-1:0] data;
  } word_t;

  word_t q[$];
  bit    model_acc;
  bit    m_drn, m_acc;
  word_t m_w;

  // Reference: a FIFO of capacity two; head is presented, full means not ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      model_acc = 1'b0;
    end else begin
      m_drn = 1'b0;
      if (q.size() > 0) m_drn = out_ready[q[0].sel];
      m_acc = in_valid && (q.size() < 2);
      if (m_drn) void'(q.pop_front());
      if (m_acc) begin
        m_w.sel  = in_sel;
        m_w.data = in_data;
        q.push_back(m_w);
      end
      model_acc = m_acc;
    end
  end

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      logic [3:0] ev;
      ev = (q.size() > 0) ? (4'b0001 << q[0].sel) : 4'b0000;
      checkOutput("model out_valid", {28'd0, out_valid}, {28'd0, ev});
      checkOutput("model in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
      checkOutput("model count", {30'd0, count}, q.size());
      if (q.size() > 0) checkOutput("model out_data", out_data, q[0].data);
    end
  end

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                               input logic [1:0] s, input logic [3:0] r);
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectState(input string tag, input logic [3:0] ov,
                             input logic [WIDTH-1:0] od, input logic [1:0] cnt,
                             input logic rdy);
    @(negedge clk);
    checkOutput({tag, " out_valid"}, {28'd0, out_valid}, {28'd0, ov});
    if (ov != 4'b0000) checkOutput({tag, " out_data"}, out_data, od);
    checkOutput({tag, " count"}, {30'd0, count}, {30'd0, cnt});
    checkOutput({tag, " in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
  endtask

  logic [WIDTH-1:0] stream_d [4];

  initial begin
    stream_d[0] = 32'h11; stream_d[1] = 32'h22;
    stream_d[2] = 32'h33; stream_d[3] = 32'h44;

    // Reset held while inputs toggle
    rst_n = 1'b0;
    applyStimulus(1'b1, 32'hDEAD, 2'd2, 4'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
      applyStimulus(1'b1, $urandom, 2'($urandom_range(0, 3)), 4'($urandom));
    end
    @(negedge clk);
    checkOutput("reset out_valid", {28'd0, out_valid}, 32'd0);
    checkOutput("reset out_data", out_data, 32'd0);
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset count", {30'd0, count}, 32'd0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h99, 2'd0, 4'hF);
    tick();
    in_valid = 1'b0;
    expectState("first", 4'b0001, 32'h99, 2'd1, 1'b1);
    tick(); tick();

    // Streaming, one word per cycle to each destination
    applyStimulus(1'b1, stream_d[0], 2'd0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) applyStimulus(1'b1, stream_d[i+1], 2'(i + 1), 4'hF);
      else in_valid = 1'b0;
      expectState("stream", 4'b0001 << i, stream_d[i], 2'd1, 1'b1);
    end
    tick(); tick();

    // Backpressure on destination 2
    applyStimulus(1'b1, 32'hA, 2'd2, 4'b1011);
    tick();
    applyStimulus(1'b1, 32'hB, 2'd0, 4'b1011);
    tick();
    applyStimulus(1'b1, 32'hC, 2'd1, 4'b1011);
    expectState("stall", 4'b0100, 32'hA, 2'd2, 1'b0);
    tick();
    expectState("stall hold", 4'b0100, 32'hA, 2'd2, 1'b0);
    tick();
    out_ready = 4'hF;
    expectState("stall last", 4'b0100, 32'hA, 2'd2, 1'b0);
    tick();
    expectState("release B", 4'b0001, 32'hB, 2'd1, 1'b1);
    tick();
    in_valid = 1'b0;
    expectState("release C", 4'b0010, 32'hC, 2'd1, 1'b1);
    tick();
    expectState("release empty", 4'b0000, 32'h0, 2'd0, 1'b1);

    // Readiness on the wrong ports must not drain
    applyStimulus(1'b1, 32'h5, 2'd3, 4'b0111);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expectState("wrong port", 4'b1000, 32'h5, 2'd1, 1'b1);
      tick();
    end
    out_ready = 4'b1000;
    tick();
    expectState("right port", 4'b0000, 32'h0, 2'd0, 1'b1);

    // Asynchronous reset while full
    applyStimulus(1'b1, 32'h61, 2'd1, 4'b0000);
    tick();
    applyStimulus(1'b1, 32'h62, 2'd2, 4'b0000);
    tick();
    in_valid = 1'b0;
    expectState("prefill", 4'b0010, 32'h61, 2'd2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async out_valid", {28'd0, out_valid}, 32'd0);
    checkOutput("async out_data", out_data, 32'd0);
    checkOutput("async count", {30'd0, count}, 32'd0);
    checkOutput("async in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    out_ready = 4'hF;
    expectState("post reset", 4'b0000, 32'h0, 2'd0, 1'b1);
    tick();
    expectState("no stale", 4'b0000, 32'h0, 2'd0, 1'b1);

    // Simultaneous drain and accept with skid empty
    applyStimulus(1'b1, 32'h7, 2'd1, 4'b0000);
    tick();
    applyStimulus(1'b1, 32'h8, 2'd2, 4'b0010);
    tick();
    applyStimulus(1'b0, 32'h0, 2'd0, 4'b0000);
    expectState("replace", 4'b0100, 32'h8, 2'd1, 1'b1);
    out_ready = 4'hF;
    tick(); tick();

    // Random traffic, source holds its word until accepted
    in_valid = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!in_valid || model_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = $urandom;
        in_sel   = 2'($urandom_range(0, 3));
      end
      out_ready = 4'($urandom);
    end
    in_valid  = 1'b0;
    out_ready = 4'hF;
    repeat (4) tick();
    expectState("final empty", 4'b0000, 32'h0, 2'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
